// File: rtl/led_channel_arbiter.sv
// Round-robin arbiter sharing one delayed-latch LED channel between two requesters.
// Latches the winner's byte, strobes begin, tracks channel busy and acks the winner.
module led_channel_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] ack,
  output logic [1:0] grant,
  output logic [7:0] led_data,
  output logic       led_begin,
  input  logic [7:0] led_state,
  output logic       err
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             owner_q, owner_d;  // index of the requester being served
  logic             last_q, last_d;    // index of the last requester served
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       led_data_q, led_data_d;
  logic             led_begin_q, led_begin_d;
  logic             err_q, err_d;
  logic             busy;
  logic             win;
  logic             unused_state;

  assign busy         = led_state[0];
  assign unused_state = ^led_state[7:1];
  assign cnt_inc      = cnt_q + CntOne;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      ack_q       <= 2'b00;
      grant_q     <= 2'b00;
      led_data_q  <= 8'h00;
      led_begin_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      grant_q     <= grant_d;
      led_data_q  <= led_data_d;
      led_begin_q <= led_begin_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    ack_d       = 2'b00;
    grant_d     = grant_q;
    led_data_d  = led_data_q;
    led_begin_d = 1'b0;
    err_d       = err_q;
    win         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // On a tie the requester not served last wins.
          win         = (req == 2'b11) ? ~last_q : req[1];
          owner_d     = win;
          grant_d     = win ? 2'b10 : 2'b01;
          led_data_d  = win ? req_data1 : req_data0;
          led_begin_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (busy) begin
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            err_d   = 1'b1;
            ack_d   = owner_q ? 2'b10 : 2'b01;
            grant_d = 2'b00;
            last_d  = owner_q;
            state_d = StDone;
          end
        end
      end
      StWaitDone: begin
        if (!busy) begin
          ack_d   = owner_q ? 2'b10 : 2'b01;
          grant_d = 2'b00;
          last_d  = owner_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign led_data  = led_data_q;
  assign led_begin = led_begin_q;
  assign err       = err_q;

endmodule

// File: doc/led_channel_arbiter.md
Name: led_channel_arbiter

Overview:
- Shares one delayed-latch LED output channel between two requesters, for example the CPU MMIO path and a debug/boot sequencer.
- Arbitrates round-robin and latches the winner's byte.
- Issues a single-cycle begin strobe to the channel, then tracks the channel's busy bit through to completion.
- Returns a one-cycle ack to the winner.
- Sits between the requesters and the LED channel; it is the only driver of the channel's data/begin inputs.

Parameters:
- TIMEOUT, 16: max cycles to wait for channel busy to rise after the begin strobe. Legal range 1..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level. Held high until the matching ack.
- req_data0  in  8  requester 0 byte. Valid while req[0]=1.
- req_data1  in  8  requester 1 byte. Valid while req[1]=1.
- ack  out  2  one-hot, one-cycle completion pulse.
- grant  out  2  one-hot current owner. 0 when idle.
- led_data  out  8  byte to the channel.
- led_begin  out  1  channel start strobe.
- led_state  in  8  channel status. Bit 0 = busy; bits 7:1 ignored.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n=0): state IDLE, ack=0, grant=0, led_data=0x00, led_begin=0, err=0, timeout counter 0, last-served pointer = requester 1 (so requester 0 wins the first tie).
- All outputs are registered (Moore). No combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - If req==00, stay in IDLE.
  - If exactly one req bit is set, grant that requester.
  - If req==11, grant the requester not equal to the last-served pointer.
  - On grant: grant<=onehot(winner), led_data<=winner's req_data, state<=ISSUE.
- ISSUE: led_begin=1 for exactly this one cycle. Counter cleared. Next state WAIT_BUSY.
- WAIT_BUSY:
  - If led_state[0]=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT without busy, set err=1 and go to DONE.
- WAIT_DONE: stay until led_state[0]=0, then go to DONE. No timeout; channel delays are long and legitimate.
- DONE:
  - ack<=onehot(winner) for one cycle.
  - grant<=0 and last-served pointer<=winner, both updated in the same cycle as the ack.
  - Next state IDLE.
- led_data holds the latched byte from grant until the next grant. Changes to req_data during service are ignored.
- Latency:
  - req sampled at edge k (IDLE) → led_begin high in cycle k+1.
  - Minimum req-to-ack is 4 cycles, for a channel that asserts busy one cycle after begin and holds it 1 cycle.
- Requester rule: drop req in the cycle after ack is seen. A req still high when IDLE samples it is treated as a new request.
- Dropping req mid-service does not abort. The transaction completes and ack is still pulsed.
- A new request from the non-owner during service waits. It wins in the IDLE cycle that follows DONE.
- err is sticky until reset. The timed-out transaction is still acked.
- Reset mid-operation returns the block to the reset values immediately. led_begin is never left asserted.

Test Plan:
1. Single requester: req=01, req_data0=0xA5; channel model asserts busy 1 cycle after begin for 5 cycles → led_begin one cycle with led_data=0xA5; ack=01 exactly once, 8 cycles after req sampled (ISSUE, 1 cycle of WAIT_BUSY, 5 busy cycles, DONE); err=0.
2. Tie from reset: req=11, data0=0x01, data1=0x02 → first grant=01 with led_data=0x01; after ack, requester 0 re-requests immediately → grant=10 with led_data=0x02 (round-robin alternation over 4 transactions).
3. Late arrival: req=10 in service; req[0] rises during WAIT_DONE → requester 0 is not granted until the IDLE cycle after ack=10; then grant=01.
4. Timeout: channel model never asserts busy → err=1 after TIMEOUT=16 cycles in WAIT_BUSY; ack pulses; err stays 1 across the following good transaction.
5. Reset mid-WAIT_DONE: pull reset_n low for 2 cycles → grant=0, ack=0, led_begin=0, led_data=0x00 asynchronously; next req=10 is serviced normally, with requester 0 favoured on any tie.
6. Data stability: change req_data0 from 0x3C to 0xFF during WAIT_DONE → led_data stays 0x3C until the next grant.
